// File: rtl/aes128_key_total.sv
// AES-128 iterative key expansion.
// Holds the previous round key and derives the next round key combinationally
// from it and the controller's round index, so round key N is available in
// the same cycle that times == N and is captured at the following edge.
module aes128_key_total (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   times,
  input  logic [127:0] key,
  output logic [127:0] keyout
);

  logic [127:0] prev_key_q;
  logic [127:0] prev_key_d;

  // FIPS-197 S-box, stored as 16 rows of 16 bytes; the high nibble selects
  // the row and the low nibble the byte within it (byte 0 in the MSBs).
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [127:0] row;
    row = '0;
    case (b[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
      default: row = '0;
    endcase
    return row[{~b[3:0], 3'b000} +: 8];
  endfunction

  // Four parallel S-box lookups, one per byte of the word.
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round constant for rounds 1..10; other indices never reach expansion.
  function automatic logic [7:0] rcon(input logic [3:0] t);
    logic [7:0] rc;
    rc = 8'h00;
    case (t)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // One step of the key schedule: w0 is the most significant word.
  function automatic logic [127:0] expand(input logic [127:0] w, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t, n0, n1, n2, n3;
    w0 = w[127:96];
    w1 = w[95:64];
    w2 = w[63:32];
    w3 = w[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Output selection: pass-through on load, expansion for rounds 1..10,
  // and a plain hold of the stored key for out-of-range indices.
  always_comb begin
    keyout     = prev_key_q;
    prev_key_d = prev_key_q;
    if (times == 4'd0) begin
      keyout = key;
    end else if (times <= 4'd10) begin
      keyout = expand(prev_key_q, rcon(times));
    end
    if (times == 4'd0) begin
      prev_key_d = key;
    end else begin
      prev_key_d = keyout;
    end
  end

  // Previous-round-key register; cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_key_q <= '0;
    end else begin
      prev_key_q <= prev_key_d;
    end
  end

endmodule

// File: tb/tb_aes128_key_total.sv
// Self-checking bench for aes128_key_total. The reference builds the S-box
// from GF(2^8) inversion plus the affine map and runs the word-level
// key-schedule recurrence, independent of the design's tables.
module tb_aes128_key_total;

  logic         clk;
  logic         rst_n;
  logic [3:0]   times;
  logic [127:0] key;
  logic [127:0] keyout;

  int n_vec;
  int n_mis;

  logic [7:0]   sb [0:255];
  logic [127:0] rk [0:10];
  logic [127:0] got_rk [0:10];

  aes128_key_total dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .times  (times),
    .key    (key),
    .keyout (keyout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sb[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] rcon_m(input int r);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < r; i++) rc = xt(rc);
    return rc;
  endfunction

  // Next round key from the previous one, via the FIPS-197 word recurrence.
  function automatic logic [127:0] next_rk(input logic [127:0] p, input int r);
    logic [31:0] w [0:7];
    logic [31:0] tmp;
    for (int j = 0; j < 4; j++) w[j] = p[127 - 32*j -: 32];
    for (int i = 4; i < 8; i++) begin
      tmp = w[i-1];
      if (i == 4) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
        tmp = tmp ^ {rcon_m(r), 24'h000000};
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4], w[5], w[6], w[7]};
  endfunction

  task automatic build_sched(input logic [127:0] k);
    rk[0] = k;
    for (int r = 1; r <= 10; r++) rk[r] = next_rk(rk[r-1], r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load k with times=0, then step rounds 1..10 checking each against the model.
  task automatic run_sched(input logic [127:0] k, input string name);
    build_sched(k);
    times = 4'd0;
    key   = k;
    #1;
    chk($sformatf("%s_load", name), keyout, k);
    tick();
    for (int r = 1; r <= 10; r++) begin
      times = 4'(r);
      #1;
      got_rk[r] = keyout;
      chk($sformatf("%s_rk%0d", name, r), keyout, rk[r]);
      tick();
    end
  endtask

  logic [127:0] fips_key, key_a, key_b, mprev, exp_v;
  int           tsel;

  initial begin
    n_vec = 0;
    n_mis = 0;
    rst_n = 1'b0;
    times = 4'd11;
    key   = '0;
    build_sbox();
    fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    // Reset state: with times out of range, keyout exposes the cleared register.
    #12;
    chk("reset_hold", keyout, 128'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("reset_after", keyout, 128'h0);
    tick();

    // FIPS-197 schedule plus known-answer spot checks.
    run_sched(fips_key, "fips");
    chk("fips_kat1",  got_rk[1],  128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_kat2",  got_rk[2],  128'hf2c295f27a96b9435935807a7359f67f);
    chk("fips_kat10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Out-of-range index after round 10 holds round key 10.
    times = 4'd11;
    #1;
    chk("hold11_a", keyout, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    times = 4'd15;
    #1;
    chk("hold15_b", keyout, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();

    // All-zero key.
    run_sched(128'h0, "zero");
    chk("zero_kat1", got_rk[1], 128'h62636363626363636263636362636363);
    chk("zero_kat2", got_rk[2], 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);

    // Back-to-back keys: B's schedule must not be contaminated by A.
    key_a = {$urandom, $urandom, $urandom, $urandom};
    key_b = {$urandom, $urandom, $urandom, $urandom};
    run_sched(key_a, "keyA");
    run_sched(key_b, "keyB");

    // Key changing while times==0 is seen combinationally.
    times = 4'd0;
    key   = key_a;
    #1;
    chk("track_a", keyout, key_a);
    key = key_b;
    #1;
    chk("track_b", keyout, key_b);
    key = fips_key;
    #1;
    chk("track_c", keyout, fips_key);
    tick();

    // Async reset during round 5, between clock edges.
    build_sched(fips_key);
    for (int r = 1; r <= 5; r++) begin
      times = 4'(r);
      #1;
      chk($sformatf("pre_rst_rk%0d", r), keyout, rk[r]);
      if (r < 5) tick();
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_r5", keyout, next_rk(128'h0, 5));
    times = 4'd11;
    #1;
    chk("async_rst_reg", keyout, 128'h0);
    tick();
    rst_n = 1'b1;
    run_sched(fips_key, "post_rst");

    // Random walk over all index values against a spec-level model.
    times = 4'd0;
    key   = {$urandom, $urandom, $urandom, $urandom};
    mprev = key;
    tick();
    for (int c = 0; c < 300; c++) begin
      tsel = int'($urandom_range(0, 19));
      times = (tsel > 15) ? 4'(tsel - 15) : 4'(tsel);
      key   = {$urandom, $urandom, $urandom, $urandom};
      if (times == 4'd0)       exp_v = key;
      else if (times <= 4'd10) exp_v = next_rk(mprev, int'(times));
      else                     exp_v = mprev;
      #1;
      chk($sformatf("rand%0d_t%0d", c, times), keyout, exp_v);
      tick();
      mprev = exp_v;
    end

    // Several full random schedules.
    for (int n = 0; n < 6; n++)
      run_sched({$urandom, $urandom, $urandom, $urandom}, $sformatf("rsched%0d", n));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
